// File: rtl/mem_fill_responder.sv
// Fixed-latency, fully pipelined single-port memory model answering cache fills.
// One request per cycle; read data emerges from the last pipe stage LATENCY cycles later.
module mem_fill_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [2:0]  outstanding
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic                 rd_accept;
  logic                 wr_accept;
  logic                 retire;
  logic                 unused_addr;

  // Stage 0 here is the first pipe stage; stage LATENCY-1 feeds the outputs.
  logic [LATENCY-1:0]   pipe_valid;
  logic [15:0]          pipe_data [LATENCY];

  assign word_idx    = addr[ADDR_BITS:1];
  assign unused_addr = ^{addr[0], addr >> (ADDR_BITS + 1)};
  assign rd_accept   = enable & ~wr;
  assign wr_accept   = enable & wr;
  assign retire      = pipe_valid[LATENCY-1];

  // NOTE: the storage array has no reset branch; clearing 2^ADDR_BITS words would
  // force it out of RAM and the contents are allowed to be undefined until written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  // NOTE: all pipeline state uses non-blocking assignments so every stage shifts
  // from the pre-edge value of its predecessor, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid  <= '0;
      outstanding <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      // Bubbles carry zero data so the output stage reads 0 whenever it is invalid.
      pipe_data[0]  <= rd_accept ? mem[word_idx] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      outstanding <= outstanding + 3'(rd_accept) - 3'(retire);
    end
  end

  assign data_out   = pipe_data[LATENCY-1];
  assign data_valid = pipe_valid[LATENCY-1];

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: a per-edge request history model predicts
// every output each cycle, and literal expectations pin the timing of key cases.
module tb_mem_fill_responder;

  localparam int LAT   = 4;
  localparam int ABITS = 10;
  localparam int HIST  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;

  mem_fill_responder #(.LATENCY(LAT), .ADDR_BITS(ABITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: what each rising edge sampled, plus a word-indexed memory image.
  int          ecount = 0;
  bit          rec_rd    [HIST];
  bit          rec_known [HIST];
  logic [15:0] rec_data  [HIST];
  logic [15:0] mem_m     [int];

  function automatic int widx(input logic [15:0] a);
    return (int'(a) >> 1) % (1 << ABITS);
  endfunction

  task automatic clear_history();
    for (int j = 0; j < HIST; j++) begin
      rec_rd[j]    = 1'b0;
      rec_known[j] = 1'b0;
    end
  endtask

  always @(posedge rst) clear_history();

  always @(posedge clk) begin
    ecount++;
    if (rst) begin
      clear_history();
    end else begin
      rec_rd[ecount]    = enable && !wr;
      rec_known[ecount] = mem_m.exists(widx(addr));
      rec_data[ecount]  = rec_known[ecount] ? mem_m[widx(addr)] : 16'h0000;
      if (enable && wr) mem_m[widx(addr)] = data_in;
    end
  end

  always @(posedge clk) begin
    if (!rst && enable) begin
      assert (!$isunknown(wr)) else $error("wr unknown while enable=1");
    end
  end

  // Every cycle: response due is the read sampled LAT-1 edges ago; outstanding
  // counts reads sampled in the last LAT edges since the last reset.
  always @(negedge clk) begin
    int k, j, cnt;
    bit ev;
    k   = ecount;
    j   = k - LAT + 1;
    ev  = (j >= 1) && rec_rd[j];
    cnt = 0;
    for (int i = (j < 1 ? 1 : j); i <= k; i++) cnt += int'(rec_rd[i]);
    if (rst) begin
      check("rst_valid", {15'b0, data_valid}, 16'h0000);
      check("rst_data", data_out, 16'h0000);
      check("rst_outstanding", {13'b0, outstanding}, 16'h0000);
    end else begin
      check("model_valid", {15'b0, data_valid}, {15'b0, ev});
      check("model_outstanding", {13'b0, outstanding}, 16'(cnt));
      if (!ev) check("model_idle_data", data_out, 16'h0000);
      else if (rec_known[j]) check("model_data", data_out, rec_data[j]);
    end
  end

  task automatic req(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = e;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;

    // Reset held with reads requested: nothing may emerge.
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    check("reset_valid", {15'b0, data_valid}, 16'h0000);
    check("reset_outstanding", {13'b0, outstanding}, 16'h0000);
    rst = 1'b0;
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(2);
    check("post_reset_early", {15'b0, data_valid}, 16'h0000);
    idle(1);
    check("post_reset_first_valid", {15'b0, data_valid}, 16'h0001);
    idle(2);

    // Single read of 0xDEAD.
    req(1'b1, 1'b1, 16'h0100, 16'hDEAD);
    idle(1);
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    check("single_out_e", {13'b0, outstanding}, 16'h0001);
    idle(2);
    check("single_not_yet", {15'b0, data_valid}, 16'h0000);
    idle(1);
    check("single_valid", {15'b0, data_valid}, 16'h0001);
    check("single_data", data_out, 16'hDEAD);
    check("single_out_e3", {13'b0, outstanding}, 16'h0001);
    idle(1);
    check("single_done_valid", {15'b0, data_valid}, 16'h0000);
    check("single_done_out", {13'b0, outstanding}, 16'h0000);

    // Block fill: 8 back-to-back reads.
    for (int i = 0; i < 8; i++) req(1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
      if (i == 3) begin
        check("fill_peak_outstanding", {13'b0, outstanding}, 16'h0004);
        check("fill_first_data", data_out, 16'h1000);
      end
      if (i == 7) check("fill_fifth_data", data_out, 16'h1004);
    end
    idle(3);
    check("fill_last_data", data_out, 16'h1007);
    idle(2);

    // Gapped reads reproduce the gap.
    req(1'b1, 1'b1, 16'h0200, 16'h2222);
    req(1'b1, 1'b1, 16'h0202, 16'h2424);
    req(1'b1, 1'b0, 16'h0200, 16'h0000);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    req(1'b1, 1'b0, 16'h0202, 16'h0000);
    idle(1);
    check("gap_first", data_out, 16'h2222);
    idle(1);
    check("gap_bubble", {15'b0, data_valid}, 16'h0000);
    idle(1);
    check("gap_second", data_out, 16'h2424);
    idle(2);

    // Write-after-read keeps the captured value.
    req(1'b1, 1'b1, 16'h0300, 16'hAAAA);
    req(1'b1, 1'b0, 16'h0300, 16'h0000);
    req(1'b1, 1'b1, 16'h0300, 16'hBBBB);
    idle(2);
    check("war_old", data_out, 16'hAAAA);
    req(1'b1, 1'b0, 16'h0300, 16'h0000);
    idle(3);
    check("war_new", data_out, 16'hBBBB);
    idle(2);

    // Reset pulse mid-burst discards in-flight reads.
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    req(1'b1, 1'b0, 16'h0102, 16'h0000);
    enable = 1'b0;
    #3 rst = 1'b1;
    #5 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      check("midrst_valid", {15'b0, data_valid}, 16'h0000);
      check("midrst_outstanding", {13'b0, outstanding}, 16'h0000);
      idle(1);
    end

    // Address wrap: 0x0804 and 0x0004 share a word.
    req(1'b1, 1'b1, 16'h0804, 16'h5A5A);
    req(1'b1, 1'b0, 16'h0004, 16'h0000);
    idle(3);
    check("wrap_data", data_out, 16'h5A5A);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Pipelined, single-port, fixed-latency main-memory model.
- Answers the cache fill FSM: accepts one read or write request per cycle and returns read data with `data_valid` exactly LATENCY cycles after the request.
- Sits between the I/D-cache fill FSMs (through the arbiter) and backing storage.
- Non-blocking: back-to-back reads stream out back-to-back, so an 8-chunk block fill completes in LATENCY+7 cycles.

Parameters:
- LATENCY, 4: cycles from request sample to consumer-sampled data; legal range 1..7.
- ADDR_BITS, 10: word-index width; array depth is 2^ADDR_BITS 16-bit words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  request strobe, sampled each rising edge.
- wr  input  1  1 = write, 0 = read; meaningful only when enable=1.
- addr  input  16  byte address; bit 0 ignored; word index = addr[ADDR_BITS:1].
- data_in  input  16  write data.
- data_out  output  16  read data; 16'h0000 whenever data_valid=0.
- data_valid  output  1  data_out carries a read response this cycle.
- outstanding  output  3  number of accepted reads not yet retired from the pipeline.

Behaviour:
- Reset:
  - rst asserted clears all pipeline valid bits and data registers immediately (asynchronous).
  - data_out=0, data_valid=0, outstanding=0 while rst=1 and until the first response.
  - The memory array is not cleared; contents are undefined until written.
- Write (enable=1, wr=1):
  - array[addr[ADDR_BITS:1]] <= data_in at the sampling edge.
  - No response is generated and outstanding is unchanged.
- Read (enable=1, wr=0):
  - The array word is read at the sampling edge (edge E) and enters pipe stage 1 with valid=1.
  - Stages shift one per edge; stage LATENCY drives data_out/data_valid.
  - data_valid is high between edges E+LATENCY-1 and E+LATENCY; the consumer samples at edge E+LATENCY.
  - Each read produces exactly one data_valid cycle.
- Idle (enable=0): a bubble (valid=0, data=0) enters stage 1.
- Throughput: one request per cycle with no stalls and no backpressure. Responses return in request order with bubbles preserved, so gaps in requests reproduce as identical gaps in data_valid.
- Read-after-write: a read issued in the cycle after a write to the same word returns the new data.
- Write-after-read: a write to a word with a read in flight does not alter the in-flight data; the read returns the value captured at edge E.
- Address wrap: index bits above ADDR_BITS are ignored, so the address aliases modulo 2^ADDR_BITS words.
- outstanding:
  - Equals the count of valid bits in stages 1..LATENCY, registered.
  - Increments on an accepted read and decrements when a valid entry leaves stage LATENCY.
  - A simultaneous accept and retire leaves it unchanged.
- Reset mid-burst: all in-flight reads are discarded and no data_valid follows. Requests sampled after rst deasserts behave normally.
- An unknown value on wr while enable=1 is illegal; the bench flags it with an assertion.

Test Plan:
- Reset: rst=1 for 2 cycles with enable=1, wr=0 -> data_valid=0, data_out=0, outstanding=0 throughout; release -> the first data_valid appears LATENCY cycles after the first sampled read.
- Single read, LATENCY=4: write 16'hDEAD to 0x0100, idle 1 cycle, read 0x0100 at edge E -> data_valid=1 and data_out=16'hDEAD only between E+3 and E+4; outstanding=1 for edges E..E+3, then 0.
- Block fill: preload 0x0100..0x010E with 16'h1000..16'h1007, then 8 back-to-back reads -> 8 consecutive data_valid cycles in order, first at E+3; outstanding peaks at 4.
- Gapped reads: reads to 0x0200, idle, 0x0202 -> valid pattern 1,0,1 with data matching the preloads.
- Write-after-read: read 0x0300 (holds 16'hAAAA), then write 16'hBBBB to 0x0300 in the next cycle -> response is 16'hAAAA; a later read returns 16'hBBBB.
- Reset mid-burst and wrap: pulse rst for half a cycle after 2 of 8 reads -> no further data_valid, outstanding=0. With ADDR_BITS=10, write to 0x0804 then read 0x0004 -> returns the written data.
